// File: rtl/exception_vector_loader_pkg.sv
// Shared constants for the exception vector loader: FSM states,
// memory-address selector codes, vector addresses and cause codes.
package exception_vector_loader_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_FETCH   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_LOAD    = 2'd3;

    localparam logic [2:0] SEL_PC         = 3'b000;
    localparam logic [2:0] SEL_ALUOUT     = 3'b001;
    localparam logic [2:0] SEL_ALURES     = 3'b010;
    localparam logic [2:0] SEL_VEC_OPCODE = 3'b011;
    localparam logic [2:0] SEL_VEC_OVF    = 3'b100;
    localparam logic [2:0] SEL_VEC_DIV0   = 3'b101;

    localparam logic [7:0] VEC_ADDR_OPCODE = 8'd253;
    localparam logic [7:0] VEC_ADDR_OVF    = 8'd254;
    localparam logic [7:0] VEC_ADDR_DIV0   = 8'd255;

    localparam logic [1:0] CAUSE_NONE   = 2'b00;
    localparam logic [1:0] CAUSE_OPCODE = 2'b01;
    localparam logic [1:0] CAUSE_OVF    = 2'b10;
    localparam logic [1:0] CAUSE_DIV0   = 2'b11;

    // Fixed priority: opcode > overflow > div0.
    function automatic logic [2:0] vec_sel(input logic op,
                                           input logic ovf,
                                           input logic div0);
        if (op)        return SEL_VEC_OPCODE;
        else if (ovf)  return SEL_VEC_OVF;
        else if (div0) return SEL_VEC_DIV0;
        else           return SEL_PC;
    endfunction

    function automatic logic [1:0] cause_of(input logic op,
                                            input logic ovf,
                                            input logic div0);
        if (op)        return CAUSE_OPCODE;
        else if (ovf)  return CAUSE_OVF;
        else if (div0) return CAUSE_DIV0;
        else           return CAUSE_NONE;
    endfunction

endpackage

// File: rtl/exception_vector_loader_latency_counter.sv
// Loadable 3-bit down-counter with zero flag; times the memory read wait.
// Ports: clk, reset (async active-low), load_i/load_val_i, dec_i, zero_o.
module latency_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_i,
    input  logic [2:0] load_val_i,
    input  logic       dec_i,
    output logic       zero_o
);

    logic [2:0] cnt_q;
    logic [2:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (dec_i && cnt_q != 3'd0)
            cnt_d = cnt_q - 3'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= 3'd0;
        else        cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == 3'd0);

endmodule

// File: rtl/exception_vector_loader.sv
// Exception sequencer: selects the vector byte address, waits MEM_LATENCY
// cycles, loads the zero-extended byte into PC and pc_in-4 into EPC.
// Ports: clk, reset (async active-low), exc_opcode/exc_overflow/exc_div0,
// pc_in, mem_data in; iord_sel, mem_wr, epc_load/epc_value,
// pc_load/pc_value, busy out. Macro EXC_CAUSE_EN adds a 2-bit cause output.
module exception_vector_loader
    import exception_vector_loader_pkg::*;
#(
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exc_opcode,
    input  logic        exc_overflow,
    input  logic        exc_div0,
    input  logic [31:0] pc_in,
    input  logic [31:0] mem_data,
    output logic [2:0]  iord_sel,
    output logic        mem_wr,
    output logic        epc_load,
    output logic [31:0] epc_value,
    output logic        pc_load,
    output logic [31:0] pc_value,
    output logic        busy
`ifdef EXC_CAUSE_EN
    ,
    output logic [1:0]  cause
`endif
);

    localparam logic [2:0] LAT_M1 = 3'(MEM_LATENCY - 1);

    logic [1:0]  state_q, state_d;
    logic [2:0]  sel_q, sel_d;
    logic        epc_load_q, epc_load_d;
    logic [31:0] epc_value_q, epc_value_d;
    logic        pc_load_q, pc_load_d;
    logic [31:0] pc_value_q, pc_value_d;
    logic        busy_q, busy_d;

    logic req;
    logic accept;
    logic cnt_dec;
    logic cnt_zero;
    logic unused_mem_hi;

    assign req           = exc_opcode | exc_overflow | exc_div0;
    assign accept        = (state_q == ST_IDLE) && req;
    assign cnt_dec       = (state_q == ST_FETCH) && !cnt_zero;
    assign unused_mem_hi = ^mem_data[31:8];

    latency_counter u_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (accept),
        .load_val_i (LAT_M1),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        epc_value_d = epc_value_q;
        pc_value_d  = pc_value_q;
        busy_d      = busy_q;
        epc_load_d  = 1'b0;
        pc_load_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d     = ST_FETCH;
                    sel_d       = vec_sel(exc_opcode, exc_overflow, exc_div0);
                    epc_value_d = pc_in - 32'd4;
                    epc_load_d  = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            ST_FETCH: begin
                if (cnt_zero) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                pc_value_d = {24'b0, mem_data[7:0]};
                pc_load_d  = 1'b1;
                state_d    = ST_LOAD;
            end
            ST_LOAD: begin
                state_d = ST_IDLE;
                sel_d   = SEL_PC;
                busy_d  = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            sel_q       <= SEL_PC;
            epc_load_q  <= 1'b0;
            epc_value_q <= 32'd0;
            pc_load_q   <= 1'b0;
            pc_value_q  <= 32'd0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            epc_load_q  <= epc_load_d;
            epc_value_q <= epc_value_d;
            pc_load_q   <= pc_load_d;
            pc_value_q  <= pc_value_d;
            busy_q      <= busy_d;
        end
    end

`ifdef EXC_CAUSE_EN
    logic [1:0] cause_q, cause_d;

    always_comb begin
        cause_d = cause_q;
        if (accept) cause_d = cause_of(exc_opcode, exc_overflow, exc_div0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cause_q <= CAUSE_NONE;
        else        cause_q <= cause_d;
    end

    assign cause = cause_q;
`endif

    assign iord_sel  = sel_q;
    assign mem_wr    = 1'b0;
    assign epc_load  = epc_load_q;
    assign epc_value = epc_value_q;
    assign pc_load   = pc_load_q;
    assign pc_value  = pc_value_q;
    assign busy      = busy_q;

endmodule
